// File: rtl/red_object_tracker_pkg.sv
`default_nettype none
// ---- tracker_pkg : shared widths, FSM states and RGB444 helpers (rev 1.0) ----
package tracker_pkg;

  localparam int CNT_W   = 19;
  localparam int SUM_W   = 28;
  localparam int COORD_W = 10;
  localparam int BOX_W   = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV_X  = 2'd1,
    S_DIV_Y  = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  function automatic logic [3:0] red_of(input logic [11:0] px);
    return px[11:8];
  endfunction

  function automatic logic [3:0] grn_of(input logic [11:0] px);
    return px[7:4];
  endfunction

  function automatic logic [3:0] blu_of(input logic [11:0] px);
    return px[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/red_object_tracker_seq_divider.sv
`default_nettype none
// ---- seq_divider : restoring unsigned divider, one quotient bit per cycle (rev 1.0) ----
module seq_divider #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 19
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q, done_q;

  logic [DIVISOR_W-1:0]  w_rem_in, w_dsr, w_sub;
  logic [DIVIDEND_W-1:0] w_quo_in;
  logic [DIVISOR_W:0]    w_shift;
  logic                  w_ge;

  // The start cycle already performs the first iteration on the fresh operands.
  always_comb begin
    w_rem_in = start ? '0 : rem_q;
    w_quo_in = start ? dividend : quo_q;
    w_dsr    = start ? divisor : dsr_q;
    w_shift  = {w_rem_in, w_quo_in[DIVIDEND_W-1]};
    w_ge     = (w_shift >= {1'b0, w_dsr});
    w_sub    = w_shift[DIVISOR_W-1:0] - w_dsr;
    rem_d    = w_ge ? w_sub : w_shift[DIVISOR_W-1:0];
    quo_d    = {w_quo_in[DIVIDEND_W-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start || busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
      if (start) begin
        dsr_q  <= divisor;
        cnt_q  <= CW'(DIVIDEND_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: rtl/red_object_tracker.sv
`default_nettype none
// ---- red_object_tracker : per-frame red blob count/centroid/box for the overlay (rev 1.0) ----
module red_object_tracker
  import tracker_pkg::*;
#(
  parameter logic [3:0] R_MIN       = 4'hA,
  parameter logic [3:0] G_MAX       = 4'h5,
  parameter logic [3:0] B_MAX       = 4'h5,
  parameter int         MIN_COUNT   = 64,
  parameter int         HOLD_FRAMES = 3,
  parameter int         H_ACT       = 640,
  parameter int         V_ACT       = 480
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic [11:0]        pixel_data,
  input  logic               frame_done,
  output logic [COORD_W-1:0] aim_x,
  output logic [COORD_W-1:0] aim_y,
  output logic               aim_detected,
  output logic [BOX_W-1:0]   box_x_min,
  output logic [BOX_W-1:0]   box_x_max,
  output logic [BOX_W-1:0]   box_y_min,
  output logic [BOX_W-1:0]   box_y_max,
  output logic               result_valid,
  output logic               busy
);

  localparam int                 MISS_W    = $clog2(HOLD_FRAMES + 2);
  localparam logic [COORD_W:0]   C_H_ACT   = (COORD_W+1)'(H_ACT);
  localparam logic [COORD_W:0]   C_V_ACT   = (COORD_W+1)'(V_ACT);
  localparam logic [COORD_W-1:0] C_X_CLAMP = COORD_W'(H_ACT - 1);
  localparam logic [COORD_W-1:0] C_Y_CLAMP = COORD_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;

  function automatic logic [COORD_W-1:0] clamp_q(input logic [SUM_W-1:0] q,
                                                 input logic [COORD_W-1:0] lim);
    return (|q[SUM_W-1:COORD_W]) ? lim : q[COORD_W-1:0];
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d, snap_cnt_q;
  logic [SUM_W-1:0]   sx_q, sx_d, sy_q, sy_d, snap_sx_q, snap_sy_q;
  logic [COORD_W-1:0] minx_q, minx_d, maxx_q, maxx_d, miny_q, miny_d, maxy_q, maxy_d;
  logic [COORD_W-1:0] snap_minx_q, snap_maxx_q, snap_miny_q, snap_maxy_q;

  state_e             state_q;
  logic               start_q, hit_q, busy_q, rv_q, det_q;
  logic [COORD_W-1:0] qx_q, qy_q, ax_q, ay_q;
  logic [BOX_W-1:0]   bx0_q, bx1_q, by0_q, by1_q;
  logic [MISS_W-1:0]  miss_q;

  logic               w_red, w_hit, w_div_done, w_div_busy;
  logic [SUM_W-1:0]   w_div_q;

  assign w_red = pixel_valid
              && ({1'b0, x_pixel} < C_H_ACT) && ({1'b0, y_pixel} < C_V_ACT)
              && (red_of(pixel_data) >= R_MIN)
              && (grn_of(pixel_data) <= G_MAX)
              && (blu_of(pixel_data) <= B_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    minx_d = minx_q;
    maxx_d = maxx_q;
    miny_d = miny_q;
    maxy_d = maxy_q;
    if (w_red) begin
      cnt_d  = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      sx_d   = sx_q + SUM_W'(x_pixel);
      sy_d   = sy_q + SUM_W'(y_pixel);
      minx_d = (x_pixel < minx_q) ? x_pixel : minx_q;
      maxx_d = (x_pixel > maxx_q) ? x_pixel : maxx_q;
      miny_d = (y_pixel < miny_q) ? y_pixel : miny_q;
      maxy_d = (y_pixel > maxy_q) ? y_pixel : maxy_q;
    end
  end

  assign w_hit = (cnt_d >= CNT_W'(MIN_COUNT));

  // A frame closing while the engine is busy still clears, but its snapshot is never taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;  sx_q <= '0;  sy_q <= '0;
      minx_q <= '1; maxx_q <= '0; miny_q <= '1; maxy_q <= '0;
      snap_cnt_q <= '0; snap_sx_q <= '0; snap_sy_q <= '0;
      snap_minx_q <= '0; snap_maxx_q <= '0; snap_miny_q <= '0; snap_maxy_q <= '0;
    end else if (frame_done) begin
      if (state_q == S_IDLE) begin
        snap_cnt_q  <= cnt_d;  snap_sx_q   <= sx_d;   snap_sy_q   <= sy_d;
        snap_minx_q <= minx_d; snap_maxx_q <= maxx_d;
        snap_miny_q <= miny_d; snap_maxy_q <= maxy_d;
      end
      cnt_q <= '0;  sx_q <= '0;  sy_q <= '0;
      minx_q <= '1; maxx_q <= '0; miny_q <= '1; maxy_q <= '0;
    end else begin
      cnt_q <= cnt_d;   sx_q <= sx_d;     sy_q <= sy_d;
      minx_q <= minx_d; maxx_q <= maxx_d; miny_q <= miny_d; maxy_q <= maxy_d;
    end
  end

  seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_q),
    .dividend ((state_q == S_DIV_Y) ? snap_sy_q : snap_sx_q),
    .divisor  (snap_cnt_q),
    .quotient (w_div_q),
    .done     (w_div_done),
    .busy     (w_div_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0; hit_q <= 1'b0; busy_q <= 1'b0; rv_q <= 1'b0; det_q <= 1'b0;
      qx_q <= '0; qy_q <= '0; ax_q <= '0; ay_q <= '0;
      bx0_q <= '0; bx1_q <= '0; by0_q <= '0; by1_q <= '0;
      miss_q <= '0;
    end else begin
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (frame_done) begin
          busy_q  <= 1'b1;
          hit_q   <= w_hit;
          start_q <= w_hit;
          state_q <= w_hit ? S_DIV_X : S_UPDATE;
        end
        S_DIV_X: if (w_div_done) begin
          qx_q    <= clamp_q(w_div_q, C_X_CLAMP);
          start_q <= 1'b1;
          state_q <= S_DIV_Y;
        end
        S_DIV_Y: if (w_div_done) begin
          qy_q    <= clamp_q(w_div_q, C_Y_CLAMP);
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          rv_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (hit_q) begin
            ax_q   <= qx_q;
            ay_q   <= qy_q;
            bx0_q  <= BOX_W'(snap_minx_q);
            bx1_q  <= BOX_W'(snap_maxx_q);
            by0_q  <= BOX_W'(snap_miny_q);
            by1_q  <= BOX_W'(snap_maxy_q);
            miss_q <= '0;
            det_q  <= 1'b1;
          end else if (miss_q < MISS_W'(HOLD_FRAMES)) begin
            miss_q <= miss_q + MISS_W'(1);
          end else begin
            det_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign aim_x        = ax_q;
  assign aim_y        = ay_q;
  assign aim_detected = det_q;
  assign box_x_min    = bx0_q;
  assign box_x_max    = bx1_q;
  assign box_y_min    = by0_q;
  assign box_y_max    = by1_q;
  assign result_valid = rv_q;
  assign busy         = busy_q | w_div_busy;

endmodule
`default_nettype wire
